// File: rtl/pwm_sample_decoder.sv
// pwm_sample_decoder: recovers the WIDTH-bit sample carried by a PWM DAC
// stream (one frame = PERIOD clocks, high for the first `value` clocks).
// Frame alignment is derived from rising edges; there is no frame strobe.
module pwm_sample_decoder #(
   parameter int WIDTH  = 8,
   parameter int PERIOD = 256   // must equal 2**WIDTH
) (
   input  logic             clk,
   input  logic             rst,          // synchronous, active-low
   input  logic             pwm_in,
   output logic [WIDTH-1:0] sample_out,
   output logic             sample_valid,
   output logic             locked,
   output logic             err
);

   localparam logic [0:0] SEEK    = 1'b0;
   localparam logic [0:0] MEASURE = 1'b1;

   // SEEK gives up after two silent frames, then reports once per frame
   localparam logic [WIDTH:0] IDLE_LIMIT  = (WIDTH+1)'(2*PERIOD-1);
   localparam logic [WIDTH:0] IDLE_RELOAD = (WIDTH+1)'(PERIOD);

   logic             sync_q, pwm_s_q, pwm_d_q;
   logic             rise;

   logic [0:0]       state_q, state_d;
   logic [WIDTH-1:0] pos_q, pos_d;
   logic [WIDTH-1:0] high_cnt_q, high_cnt_d;
   logic [WIDTH:0]   idle_cnt_q, idle_cnt_d;
   logic [WIDTH-1:0] sample_q, sample_d;
   logic             valid_q, valid_d;
   logic             locked_q, locked_d;
   logic             err_q, err_d;

   // Two-flop synchroniser plus one delayed copy for edge detection
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_q  <= 1'b0;
         pwm_s_q <= 1'b0;
         pwm_d_q <= 1'b0;
      end else begin
         sync_q  <= pwm_in;
         pwm_s_q <= sync_q;
         pwm_d_q <= pwm_s_q;
      end
   end

   assign rise = pwm_s_q & ~pwm_d_q;

   // Frame search / measurement next-state logic
   always_comb begin
      state_d    = state_q;
      pos_d      = pos_q;
      high_cnt_d = high_cnt_q;
      idle_cnt_d = idle_cnt_q;
      sample_d   = sample_q;
      valid_d    = 1'b0;
      locked_d   = locked_q;
      err_d      = 1'b0;

      case (state_q)
         SEEK: begin
            // A rise always wins over the idle timeout landing on the same
            // cycle: the line is clearly toggling, so start measuring.
            if (rise) begin
               state_d    = MEASURE;
               pos_d      = WIDTH'(1);
               high_cnt_d = WIDTH'(1);
               idle_cnt_d = '0;
            end else if (idle_cnt_q == IDLE_LIMIT) begin
               idle_cnt_d = IDLE_RELOAD;
               if (pwm_s_q) begin
                  err_d = 1'b1;           // stuck high, nothing to report
               end else begin
                  sample_d = '0;          // silent line means value 0
                  valid_d  = 1'b1;
               end
            end else begin
               idle_cnt_d = idle_cnt_q + 1'b1;
            end
         end

         MEASURE: begin
            pos_d = pos_q + 1'b1;
            if (pos_q != '0) begin
               if (rise) begin
                  // Misaligned or second pulse: realign on this edge
                  err_d      = 1'b1;
                  locked_d   = 1'b0;
                  pos_d      = WIDTH'(1);
                  high_cnt_d = WIDTH'(1);
               end else begin
                  high_cnt_d = high_cnt_q + WIDTH'(pwm_s_q);
               end
            end else if (pwm_s_q && pwm_d_q) begin
               // High across a whole frame: no legal DAC value does this
               err_d      = 1'b1;
               locked_d   = 1'b0;
               state_d    = SEEK;
               idle_cnt_d = '0;
            end else begin
               sample_d   = high_cnt_q;
               valid_d    = 1'b1;
               locked_d   = 1'b1;
               high_cnt_d = WIDTH'(pwm_s_q);
            end
         end

         default: state_d = SEEK;
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= SEEK;
         pos_q      <= '0;
         high_cnt_q <= '0;
         idle_cnt_q <= '0;
         sample_q   <= '0;
         valid_q    <= 1'b0;
         locked_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pos_q      <= pos_d;
         high_cnt_q <= high_cnt_d;
         idle_cnt_q <= idle_cnt_d;
         sample_q   <= sample_d;
         valid_q    <= valid_d;
         locked_q   <= locked_d;
         err_q      <= err_d;
      end
   end

   assign sample_out   = sample_q;
   assign sample_valid = valid_q;
   assign locked       = locked_q;
   assign err          = err_q;

endmodule

// File: tb/tb_pwm_sample_decoder.sv
// Testbench for pwm_sample_decoder: drives DAC-shaped PWM frames and checks
// every sample_valid / err pulse against a queue of expected events.
module tb_pwm_sample_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       pwm_in = 1'b0;
   logic [7:0] sample_out;
   logic       sample_valid, locked, err;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int force_left = 0;

   typedef struct {
      int         cyc;
      bit         is_err;
      logic [7:0] val;
      bit         lock;
   } exp_t;

   exp_t sb[$];

   pwm_sample_decoder #(.WIDTH(8), .PERIOD(256)) dut (
      .clk          (clk),
      .rst          (rst),
      .pwm_in       (pwm_in),
      .sample_out   (sample_out),
      .sample_valid (sample_valid),
      .locked       (locked),
      .err          (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: every output pulse must match the head of the queue
   always @(negedge clk) begin
      exp_t e;
      if (sample_valid === 1'b1 || err === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse: cyc=%0d valid=%b err=%b out=%0d, required no pulse",
                     cyc, sample_valid, err, sample_out);
         end else begin
            e = sb.pop_front();
            if (cyc !== e.cyc || err !== e.is_err || sample_valid !== !e.is_err ||
                locked !== e.lock || (!e.is_err && sample_out !== e.val)) begin
               errors++;
               $display("FAIL scoreboard: got cyc=%0d valid=%b err=%b locked=%b out=%0d, required cyc=%0d err=%b locked=%b out=%0d",
                        cyc, sample_valid, err, locked, sample_out, e.cyc, e.is_err, e.lock, e.val);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   task automatic expect_sample(input int c, input int v, input bit l);
      exp_t e;
      e.cyc = c; e.is_err = 1'b0; e.val = 8'(v); e.lock = l;
      sb.push_back(e);
   endtask

   task automatic expect_err(input int c);
      exp_t e;
      e.cyc = c; e.is_err = 1'b1; e.val = 8'd0; e.lock = 1'b0;
      sb.push_back(e);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      pwm_in = 1'b0;
      force_left = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   // Drive DAC counter positions lo..hi of one frame with value v
   task automatic run_part(input int v, input int lo, input int hi,
                           input int glitch_at, input int force_at);
      for (int i = lo; i <= hi; i++) begin
         @(posedge clk);
         #1;
         if (i == force_at) force_left = 600;
         if (force_left > 0) begin
            pwm_in = 1'b1;
            force_left--;
         end else if (glitch_at >= 0 && i == glitch_at - 1) begin
            pwm_in = 1'b0;
         end else begin
            pwm_in = (i < v);
         end
      end
   endtask

   task automatic frame(input int v);
      run_part(v, 0, 255, -1, -1);
   endtask

   task automatic trail();
      repeat (8) begin
         @(posedge clk);
         #1 pwm_in = 1'b0;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++; if (sample_out !== 8'd0) begin errors++; $display("FAIL reset_sample_out: got %0d, required 0", sample_out); end
      checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", sample_valid); end
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b, required 0", locked); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b, required 0", err); end
   endtask

   task automatic test_steady();
      int b;
      do_reset();
      b = cyc + 1;
      for (int k = 0; k < 4; k++) expect_sample(b + 256*k + 259, 100, 1'b1);
      for (int k = 0; k < 4; k++) frame(100);
      trail();
      checks++; if (sample_out !== 8'd100) begin errors++; $display("FAIL steady_hold: got %0d, required 100", sample_out); end
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL steady_locked: got %b, required 1", locked); end
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL steady_pending: %0d pulses missing, required 0", sb.size()); sb.delete(); end
   endtask

   task automatic test_all_zero();
      int rel;
      do_reset();
      rel = cyc;
      for (int k = 0; k < 3; k++) expect_sample(rel + 512 + 256*k, 0, 1'b0);
      for (int k = 0; k < 4; k++) frame(0);
      trail();
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL zero_locked: got %b, required 0", locked); end
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL zero_pending: %0d pulses missing, required 0", sb.size()); sb.delete(); end
   endtask

   task automatic test_full_scale();
      int b;
      int vals[5] = '{255, 255, 255, 1, 1};
      do_reset();
      b = cyc + 1;
      for (int k = 0; k < 5; k++) expect_sample(b + 256*k + 259, vals[k], 1'b1);
      for (int k = 0; k < 5; k++) frame(vals[k]);
      trail();
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL full_locked: got %b, required 1", locked); end
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL full_pending: %0d pulses missing, required 0", sb.size()); sb.delete(); end
   endtask

   task automatic test_value_change();
      int b;
      int vals[4] = '{100, 100, 0, 37};
      do_reset();
      b = cyc + 1;
      for (int k = 0; k < 4; k++) expect_sample(b + 256*k + 259, vals[k], 1'b1);
      for (int k = 0; k < 4; k++) frame(vals[k]);
      trail();
      checks++; if (sample_out !== 8'd37) begin errors++; $display("FAIL change_last: got %0d, required 37", sample_out); end
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL change_pending: %0d pulses missing, required 0", sb.size()); sb.delete(); end
   endtask

   task automatic test_stuck_high();
      int b;
      do_reset();
      b = cyc + 1;
      expect_sample(b + 259, 100, 1'b1);
      expect_err(b + 2*256 + 3);
      expect_sample(b + 4*256 + 259, 60, 1'b1);
      expect_sample(b + 5*256 + 259, 60, 1'b1);
      frame(100);
      run_part(100, 0, 255, -1, 50);
      for (int k = 0; k < 4; k++) frame(60);
      trail();
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL stuck_relock: got %b, required 1", locked); end
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL stuck_pending: %0d pulses missing, required 0", sb.size()); sb.delete(); end
   endtask

   task automatic test_extra_rise();
      int b;
      do_reset();
      b = cyc + 1;
      expect_sample(b + 259, 100, 1'b1);
      expect_err(b + 256 + 43);
      expect_err(b + 2*256 + 3);
      expect_sample(b + 2*256 + 259, 100, 1'b1);
      expect_sample(b + 3*256 + 259, 100, 1'b1);
      frame(100);
      run_part(100, 0, 255, 40, -1);
      frame(100);
      frame(100);
      trail();
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL glitch_pending: %0d pulses missing, required 0", sb.size()); sb.delete(); end
   endtask

   task automatic test_reset_midframe();
      int b;
      do_reset();
      b = cyc + 1;
      expect_sample(b + 259, 100, 1'b1);
      expect_sample(b + 256 + 259, 100, 1'b1);
      expect_sample(b + 3*256 + 259, 100, 1'b1);
      expect_sample(b + 4*256 + 259, 100, 1'b1);
      frame(100);
      frame(100);
      run_part(100, 0, 123, -1, -1);
      rst = 1'b0;
      run_part(100, 124, 124, -1, -1);
      checks++; if (sample_out !== 8'd0) begin errors++; $display("FAIL midrst_sample_out: got %0d, required 0", sample_out); end
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL midrst_locked: got %b, required 0", locked); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL midrst_err: got %b, required 0", err); end
      checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b, required 0", sample_valid); end
      rst = 1'b1;
      run_part(100, 125, 255, -1, -1);
      frame(100);
      frame(100);
      trail();
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL midrst_pending: %0d pulses missing, required 0", sb.size()); sb.delete(); end
   endtask

   initial begin
      test_reset();
      test_steady();
      test_all_zero();
      test_full_scale();
      test_value_change();
      test_stuck_high();
      test_extra_rise();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
